// File: rtl/univ_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_pkg
//   Shared definitions for the universal shift register: the 2-bit operation
//   code type, its encodings, and a small decode helper.
//
//   Contents
//     mode_t      : 2-bit operation code carried on the `mode` port
//     MODE_HOLD   : 2'b00  keep contents
//     MODE_SHR    : 2'b01  shift towards bit 0, serial data enters the MSB
//     MODE_SHL    : 2'b10  shift towards the MSB, serial data enters bit 0
//     MODE_LOAD   : 2'b11  parallel load
//     is_shift()  : true for SHR and SHL (the operations that advance cnt)
// -----------------------------------------------------------------------------
package univ_shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    // Both shift directions count as one shift each; the counter tracks how
    // many shifts happened, not where the word currently sits.
    function automatic logic is_shift(input mode_t m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage : univ_shift_reg_pkg

// File: rtl/univ_shift_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear. Counts from 0 up to MAX and
//   then sticks at MAX until cleared or reset; it never wraps.
//
//   Parameters
//     MAX      : saturation value (must fit in CW bits)
//     CW       : counter width
//
//   Ports
//     clk      in   1   rising-edge clock
//     reset_n  in   1   synchronous active-low reset, forces cnt to 0
//     en       in   1   clock enable; 0 = counter holds (clr and inc ignored)
//     clr      in   1   synchronous clear to 0 (wins over inc)
//     inc      in   1   advance by one unless already at MAX
//     cnt      out  CW  current count
//     at_max   out  1   cnt == MAX (combinational from the register)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int MAX = 8,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    if (CW < 1) begin : g_bad_cw
        $error("sat_counter: CW must be at least 1");
    end
    if (MAX < 1 || MAX >= (2 ** CW)) begin : g_bad_max
        $error("sat_counter: MAX must be in 1 .. 2**CW-1");
    end

    localparam logic [CW-1:0] MAX_C = CW'(MAX);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_C);

endmodule : sat_counter

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised N-bit universal shift register: hold, shift right, shift left
//   and parallel load, with complemented outputs and both serial outputs.
//   A saturating shift counter reports how many shifts have happened since the
//   last load or reset, and full_shift flags that a whole word has moved.
//   Intended as the SERDES primitive for serial links and LED/display chains.
//
//   Optional feature (macro USR_ROTATE_EN):
//     defined   -> extra input `rot`; with rot=1 a shift recirculates the bit
//                  leaving the register instead of taking sin_msb/sin_lsb.
//     undefined -> no `rot` port; shifts always take the serial inputs.
//
//   Parameters
//     WIDTH      : storage bits, >= 2
//     RESET_VAL  : contents of q after reset
//
//   Ports
//     clk        in   1      rising-edge clock
//     reset_n    in   1      synchronous active-low reset (beats en and mode)
//     en         in   1      clock enable; 0 = q and cnt hold
//     mode       in   2      00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//     d          in   WIDTH  parallel load data
//     sin_msb    in   1      serial bit entering bit WIDTH-1 on SHR
//     sin_lsb    in   1      serial bit entering bit 0 on SHL
//     rot        in   1      rotate select (only with USR_ROTATE_EN)
//     q          out  WIDTH  register contents
//     qb         out  WIDTH  ~q
//     sout_lsb   out  1      q[0], the bit leaving on SHR
//     sout_msb   out  1      q[WIDTH-1], the bit leaving on SHL
//     cnt        out  CW     shifts since last load/reset, CW = $clog2(WIDTH+1)
//     full_shift out  1      cnt == WIDTH
// -----------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_msb,
    input  logic                         sin_lsb,
`ifdef USR_ROTATE_EN
    input  logic                         rot,
`endif
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qb,
    output logic                         sout_lsb,
    output logic                         sout_msb,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         full_shift
);

    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("univ_shift_reg: WIDTH must be at least 2");
    end

    mode_t            mode_w;
    logic             rot_w;
    logic             fill_msb;
    logic             fill_lsb;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             cnt_clr;
    logic             cnt_inc;

    assign mode_w = mode_t'(mode);

`ifdef USR_ROTATE_EN
    assign rot_w = rot;
`else
    assign rot_w = 1'b0;
`endif

    // In rotate mode the bit falling off one end re-enters at the other, so
    // a WIDTH-long run of rotates returns the word to its starting position.
    assign fill_msb = rot_w ? q_q[0]       : sin_msb;
    assign fill_lsb = rot_w ? q_q[WIDTH-1] : sin_lsb;

    always_comb begin
        q_d = q_q;
        unique case (mode_w)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = {fill_msb, q_q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_lsb};
            MODE_LOAD: q_d = d;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= RESET_VAL;
        end else if (en) begin
            q_q <= q_d;
        end
    end

    // A load starts a fresh word, so it clears the count; shifts advance it.
    assign cnt_clr = (mode_w == MODE_LOAD);
    assign cnt_inc = is_shift(mode_w);

    sat_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .cnt     (cnt),
        .at_max  (full_shift)
    );

    assign q        = q_q;
    assign qb       = ~q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int         WIDTH = 8;
    localparam int         CW    = $clog2(WIDTH + 1);
    localparam logic [7:0] RV    = 8'hA5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [1:0]    mode;
    logic [7:0]    d;
    logic          sin_msb;
    logic          sin_lsb;
`ifdef USR_ROTATE_EN
    logic          rot;
`endif
    logic [7:0]    q;
    logic [7:0]    qb;
    logic          sout_lsb;
    logic          sout_msb;
    logic [CW-1:0] cnt;
    logic          full_shift;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .mode       (mode),
        .d          (d),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .q          (q),
        .qb         (qb),
        .sout_lsb   (sout_lsb),
        .sout_msb   (sout_msb),
        .cnt        (cnt),
        .full_shift (full_shift)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset_n = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00;
        sin_msb = 1'b0; sin_lsb = 1'b0;
`ifdef USR_ROTATE_EN
        rot = 1'b0;
`endif

        // 1. reset
        step();
        chk("rst_q",    q,          32'hA5);
        chk("rst_qb",   qb,         32'h5A);
        chk("rst_cnt",  cnt,        32'h0);
        chk("rst_full", full_shift, 32'h0);
        chk("rst_souts", {sout_msb, sout_lsb}, 32'h3);

        // 2. LOAD 81 then 3x SHR with sin_msb=0
        reset_n = 1'b1; en = 1'b1; mode = 2'b11; d = 8'h81;
        step();
        chk("ld81_q",   q,        32'h81);
        chk("ld81_cnt", cnt,      32'h0);
        chk("shr_sout0", sout_lsb, 32'h1);
        mode = 2'b01; sin_msb = 1'b0;
        step();
        chk("shr1_q",    q,        32'h40);
        chk("shr_sout1", sout_lsb, 32'h0);
        step();
        chk("shr_sout2", sout_lsb, 32'h0);
        step();
        chk("shr3_q",   q,   32'h10);
        chk("shr3_qb",  qb,  32'hEF);
        chk("shr3_cnt", cnt, 32'h3);
        mode = 2'b00;
        step();
        chk("hold_q",   q,   32'h10);
        chk("hold_cnt", cnt, 32'h3);

        // 3. LOAD 00 then 8x SHL with sin_lsb=1, then a 9th
        mode = 2'b11; d = 8'h00;
        step();
        chk("ld00_q", q, 32'h00);
        mode = 2'b10; sin_lsb = 1'b1;
        for (int i = 1; i <= 7; i++) step();
        chk("shl7_q",    q,          32'h7F);
        chk("shl7_cnt",  cnt,        32'h7);
        chk("shl7_full", full_shift, 32'h0);
        step();
        chk("shl8_q",    q,          32'hFF);
        chk("shl8_cnt",  cnt,        32'h8);
        chk("shl8_full", full_shift, 32'h1);
        chk("shl8_smsb", sout_msb,   32'h1);
        step();
        chk("shl9_q",    q,          32'hFF);
        chk("shl9_cnt",  cnt,        32'h8);
        chk("shl9_full", full_shift, 32'h1);

        // 4. en=0 with SHR for 5 edges, then resume
        en = 1'b0; mode = 2'b01; sin_msb = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("en0_q",   q,   32'hFF);
        chk("en0_cnt", cnt, 32'h8);
        en = 1'b1;
        step();
        chk("resume_q",   q,   32'h7F);
        chk("resume_cnt", cnt, 32'h8);

        // 5. LOAD 0F, 4x SHR sin_msb=1, then reset while LOAD is requested
        mode = 2'b11; d = 8'h0F;
        step();
        mode = 2'b01; sin_msb = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("shr4_q",   q,   32'hF0);
        chk("shr4_cnt", cnt, 32'h4);
        reset_n = 1'b0; mode = 2'b11; d = 8'hFF;
        step();
        chk("midrst_q",    q,          32'hA5);
        chk("midrst_cnt",  cnt,        32'h0);
        chk("midrst_full", full_shift, 32'h0);
        reset_n = 1'b1; mode = 2'b01; sin_msb = 1'b0;
        step();
        chk("postrst_q",   q,   32'h52);
        chk("postrst_cnt", cnt, 32'h1);
        // reset also beats en=0
        en = 1'b0; reset_n = 1'b0;
        step();
        chk("rst_en0_q",   q,   32'hA5);
        chk("rst_en0_cnt", cnt, 32'h0);
        reset_n = 1'b1; en = 1'b1;

`ifdef USR_ROTATE_EN
        // 6. rotate
        rot = 1'b1; mode = 2'b11; d = 8'h01;
        step();
        mode = 2'b01; sin_msb = 1'b0;
        step();
        chk("rotr_q", q, 32'h80);
        mode = 2'b10; sin_lsb = 1'b0;
        step();
        chk("rotl_q",   q,   32'h01);
        chk("rotl_cnt", cnt, 32'h2);
        rot = 1'b0; mode = 2'b01; sin_msb = 1'b0;
        step();
        chk("norot_q",   q,   32'h00);
        chk("norot_cnt", cnt, 32'h3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg
